// File: rtl/mmul_pkg.sv
// Shared types and helpers for the matrix multiplier datapath and its
// result streamer.
package mmul_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Index width that never collapses to zero bits for 1-element dimensions.
  function automatic int safe_clog2(input int n);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mat_streamer_if.sv
// Element stream produced by mat_streamer: data, indices, framing and
// a valid/ready handshake.
interface mat_streamer_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 1,
  parameter int CW    = 1
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_row;
  logic [CW-1:0]    out_col;
  logic             out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/mat_idx_counter.sv
// Row/column wrap counter for an M x L frame, row-major or column-major,
// with a registered last-element flag.
module mat_idx_counter
  import mmul_pkg::*;
#(
  parameter int M         = 1,
  parameter int L         = 1,
  parameter int COL_MAJOR = 0,
  parameter int RW        = safe_clog2(M),
  parameter int CW        = safe_clog2(L)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [RW-1:0] nxt_row,
  output logic [CW-1:0] nxt_col,
  output logic          last
);

  logic row_end_s;
  logic col_end_s;

  assign row_end_s = (row == RW'(M - 1));
  assign col_end_s = (col == CW'(L - 1));

  // Next index: clear wins over advance; the minor dimension wraps into the major one.
  always_comb begin
    nxt_row = row;
    nxt_col = col;
    if (clear) begin
      nxt_row = '0;
      nxt_col = '0;
    end else if (advance) begin
      if (COL_MAJOR != 0) begin
        if (row_end_s) begin
          nxt_row = '0;
          nxt_col = col_end_s ? '0 : col + CW'(1'b1);
        end else begin
          nxt_row = row + RW'(1'b1);
        end
      end else begin
        if (col_end_s) begin
          nxt_col = '0;
          nxt_row = row_end_s ? '0 : row + RW'(1'b1);
        end else begin
          nxt_col = col + CW'(1'b1);
        end
      end
    end else begin
      nxt_row = row;
      nxt_col = col;
    end
  end

  // Index registers; last is registered so it reads 0 out of reset even for 1x1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row  <= '0;
      col  <= '0;
      last <= 1'b0;
    end else begin
      row  <= nxt_row;
      col  <= nxt_col;
      last <= (nxt_row == RW'(M - 1)) && (nxt_col == CW'(L - 1));
    end
  end

endmodule

// File: rtl/mat_streamer.sv
// Captures a flat M x L result matrix on load and streams it out one
// element per accepted handshake, tagged with row/column and last.
module mat_streamer
  import mmul_pkg::*;
#(
  parameter int M         = 0,
  parameter int L         = 0,
  parameter int WIDTH     = 8,
  parameter int COL_MAJOR = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [M*L*WIDTH-1:0]   mat_in,
  input  logic                   load,
  mat_streamer_if.master         ms,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int RW = safe_clog2(M);
  localparam int CW = safe_clog2(L);
  localparam int NE = M * L;

  if (M == 0 || L == 0) begin : g_bad_dims
    $error("mat_streamer: M and L must both be nonzero");
  end

  state_t               state_r;
  state_t               state_nxt_s;
  logic [NE*WIDTH-1:0]  hold_r;
  logic [WIDTH-1:0]     data_r;
  logic [WIDTH-1:0]     next_elem_s;
  logic                 frame_done_r;
  logic                 overrun_r;
  logic                 valid_s;
  logic                 xfer_s;
  logic                 capture_s;
  logic                 advance_s;
  logic                 drop_s;
  logic [RW-1:0]        row_s;
  logic [CW-1:0]        col_s;
  logic [RW-1:0]        nxt_row_s;
  logic [CW-1:0]        nxt_col_s;
  logic                 last_s;
  int                   idx_s;

  assign valid_s = (state_r == STREAM);
  assign xfer_s  = valid_s & ms.out_ready;

  mat_idx_counter #(
    .M         (M),
    .L         (L),
    .COL_MAJOR (COL_MAJOR),
    .RW        (RW),
    .CW        (CW)
  ) u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (capture_s),
    .advance (advance_s),
    .row     (row_s),
    .col     (col_s),
    .nxt_row (nxt_row_s),
    .nxt_col (nxt_col_s),
    .last    (last_s)
  );

  // FSM next state; a load coinciding with the final transfer starts the next frame.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    advance_s   = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (load) begin
          capture_s   = 1'b1;
          state_nxt_s = STREAM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (xfer_s && last_s) begin
          advance_s = 1'b1;
          if (load) begin
            capture_s   = 1'b1;
            state_nxt_s = STREAM;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (xfer_s) begin
          advance_s = 1'b1;
          drop_s    = load;
        end else begin
          drop_s = load;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Element of the held frame at the index the counter moves to next.
  always_comb begin
    idx_s       = int'(nxt_row_s) * L + int'(nxt_col_s);
    next_elem_s = '0;
    for (int k = 0; k < NE; k++) begin
      next_elem_s = (k == idx_s) ? hold_r[k*WIDTH +: WIDTH] : next_elem_s;
    end
  end

  // State, frame holding register, output data and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      hold_r       <= '0;
      data_r       <= '0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      hold_r       <= capture_s ? mat_in : hold_r;
      data_r       <= capture_s ? mat_in[WIDTH-1:0] :
                      advance_s ? next_elem_s : data_r;
      frame_done_r <= xfer_s & last_s;
      overrun_r    <= overrun_r | drop_s;
    end
  end

  assign ms.out_data  = data_r;
  assign ms.out_valid = valid_s;
  assign ms.out_row   = row_s;
  assign ms.out_col   = col_s;
  assign ms.out_last  = last_s;
  assign busy         = valid_s;
  assign frame_done   = frame_done_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_mat_streamer.sv
// Directed, table-driven bench for mat_streamer: 2x2 row/column-major,
// 2x3 with overrun and back-to-back frames, 1x1, and mid-frame reset.
module tb_mat_streamer;

  typedef struct {
    logic        load;
    logic        ready;
    logic [47:0] mat;
    int          valid;
    int          data;
    int          row;
    int          col;
    int          last;
    int          done;
    int          busy;
    int          ov;
  } vec_t;

  localparam logic [47:0] MA  = 48'h0000_0403_0201;
  localparam logic [47:0] MX  = 48'h0000_DEAD_BEEF;
  localparam logic [47:0] MC1 = 48'h2322_2113_1211;
  localparam logic [47:0] MCX = 48'hEEEE_EEEE_EEEE;
  localparam logic [47:0] MC2 = 48'h3635_3433_3231;
  localparam logic [47:0] MD  = 48'h0000_0000_00A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mat_a, mat_b;
  logic [47:0] mat_c;
  logic [7:0]  mat_d;
  logic        load_a, load_b, load_c, load_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;
  logic        ov_a, ov_b, ov_c, ov_d;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mat_streamer_if #(.WIDTH(8), .RW(1), .CW(1)) if_a ();
  mat_streamer_if #(.WIDTH(8), .RW(1), .CW(1)) if_b ();
  mat_streamer_if #(.WIDTH(8), .RW(1), .CW(2)) if_c ();
  mat_streamer_if #(.WIDTH(8), .RW(1), .CW(1)) if_d ();

  mat_streamer #(.M(2), .L(2), .WIDTH(8), .COL_MAJOR(0)) u_a (
    .clk(clk), .reset(reset), .mat_in(mat_a), .load(load_a), .ms(if_a),
    .busy(busy_a), .frame_done(done_a), .overrun(ov_a));
  mat_streamer #(.M(2), .L(2), .WIDTH(8), .COL_MAJOR(1)) u_b (
    .clk(clk), .reset(reset), .mat_in(mat_b), .load(load_b), .ms(if_b),
    .busy(busy_b), .frame_done(done_b), .overrun(ov_b));
  mat_streamer #(.M(2), .L(3), .WIDTH(8), .COL_MAJOR(0)) u_c (
    .clk(clk), .reset(reset), .mat_in(mat_c), .load(load_c), .ms(if_c),
    .busy(busy_c), .frame_done(done_c), .overrun(ov_c));
  mat_streamer #(.M(1), .L(1), .WIDTH(8), .COL_MAJOR(0)) u_d (
    .clk(clk), .reset(reset), .mat_in(mat_d), .load(load_d), .ms(if_d),
    .busy(busy_d), .frame_done(done_d), .overrun(ov_d));

  function automatic vec_t mk(input logic ld, input logic rd, input logic [47:0] m,
                              input int vl, input int d, input int r, input int c,
                              input int l, input int dn, input int b, input int ov);
    vec_t v;
    v.load = ld; v.ready = rd; v.mat = m;
    v.valid = vl; v.data = d; v.row = r; v.col = c;
    v.last = l; v.done = dn; v.busy = b; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int dut, input vec_t v);
    case (dut)
      0: begin load_a = v.load; if_a.out_ready = v.ready; mat_a = v.mat[31:0]; end
      1: begin load_b = v.load; if_b.out_ready = v.ready; mat_b = v.mat[31:0]; end
      2: begin load_c = v.load; if_c.out_ready = v.ready; mat_c = v.mat; end
      default: begin load_d = v.load; if_d.out_ready = v.ready; mat_d = v.mat[7:0]; end
    endcase
  endtask

  task automatic sample(input int dut, output vec_t s);
    s.load = 1'b0; s.ready = 1'b0; s.mat = '0;
    case (dut)
      0: begin
        s.valid = int'(if_a.out_valid); s.data = int'(if_a.out_data);
        s.row = int'(if_a.out_row); s.col = int'(if_a.out_col); s.last = int'(if_a.out_last);
        s.done = int'(done_a); s.busy = int'(busy_a); s.ov = int'(ov_a);
      end
      1: begin
        s.valid = int'(if_b.out_valid); s.data = int'(if_b.out_data);
        s.row = int'(if_b.out_row); s.col = int'(if_b.out_col); s.last = int'(if_b.out_last);
        s.done = int'(done_b); s.busy = int'(busy_b); s.ov = int'(ov_b);
      end
      2: begin
        s.valid = int'(if_c.out_valid); s.data = int'(if_c.out_data);
        s.row = int'(if_c.out_row); s.col = int'(if_c.out_col); s.last = int'(if_c.out_last);
        s.done = int'(done_c); s.busy = int'(busy_c); s.ov = int'(ov_c);
      end
      default: begin
        s.valid = int'(if_d.out_valid); s.data = int'(if_d.out_data);
        s.row = int'(if_d.out_row); s.col = int'(if_d.out_col); s.last = int'(if_d.out_last);
        s.done = int'(done_d); s.busy = int'(busy_d); s.ov = int'(ov_d);
      end
    endcase
  endtask

  // Full comparison of one DUT's outputs; index fields only matter while valid.
  task automatic compare(input int dut, input vec_t v, input string nm);
    vec_t s;
    sample(dut, s);
    chk({nm, ".valid"}, s.valid, v.valid);
    chk({nm, ".busy"},  s.busy,  v.busy);
    chk({nm, ".done"},  s.done,  v.done);
    chk({nm, ".ovr"},   s.ov,    v.ov);
    if (v.valid != 0) begin
      chk({nm, ".data"}, s.data, v.data);
      chk({nm, ".row"},  s.row,  v.row);
      chk({nm, ".col"},  s.col,  v.col);
      chk({nm, ".last"}, s.last, v.last);
    end
  endtask

  task automatic run_vec(input int dut, input vec_t v, input string tag, input int step);
    apply(dut, v);
    @(posedge clk);
    #1;
    compare(dut, v, $sformatf("%s[%0d]", tag, step));
  endtask

  initial begin
    vec_t ta[$], tbv[$], tc[$], td[$];
    vec_t zero_v;
    string tags[4] = '{"rm2x2", "cm2x2", "rm2x3", "one1x1"};

    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0; load_d = 1'b0;
    mat_a = '0; mat_b = '0; mat_c = '0; mat_d = '0;
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
    if_c.out_ready = 1'b0; if_d.out_ready = 1'b0;

    //                   ld    rd    mat  vl  data  r  c  lst dn bsy ov
    ta.push_back(mk(1'b1, 1'b1, MA,  1, 'h01, 0, 0, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MA,  1, 'h02, 0, 1, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MA,  1, 'h03, 1, 0, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MA,  1, 'h04, 1, 1, 1, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MA,  0, 0,    0, 0, 0, 1, 0, 0));
    ta.push_back(mk(1'b0, 1'b1, MA,  0, 0,    0, 0, 0, 0, 0, 0));
    ta.push_back(mk(1'b1, 1'b0, MA,  1, 'h01, 0, 0, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MX,  1, 'h02, 0, 1, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b0, MX,  1, 'h02, 0, 1, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b0, MX,  1, 'h02, 0, 1, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MX,  1, 'h03, 1, 0, 0, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MX,  1, 'h04, 1, 1, 1, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b0, MX,  1, 'h04, 1, 1, 1, 0, 1, 0));
    ta.push_back(mk(1'b0, 1'b1, MX,  0, 0,    0, 0, 0, 1, 0, 0));

    tbv.push_back(mk(1'b1, 1'b1, MA, 1, 'h01, 0, 0, 0, 0, 1, 0));
    tbv.push_back(mk(1'b0, 1'b1, MA, 1, 'h03, 1, 0, 0, 0, 1, 0));
    tbv.push_back(mk(1'b0, 1'b1, MA, 1, 'h02, 0, 1, 0, 0, 1, 0));
    tbv.push_back(mk(1'b0, 1'b1, MA, 1, 'h04, 1, 1, 1, 0, 1, 0));
    tbv.push_back(mk(1'b0, 1'b1, MA, 0, 0,    0, 0, 0, 1, 0, 0));

    tc.push_back(mk(1'b1, 1'b1, MC1, 1, 'h11, 0, 0, 0, 0, 1, 0));
    tc.push_back(mk(1'b0, 1'b1, MC1, 1, 'h12, 0, 1, 0, 0, 1, 0));
    tc.push_back(mk(1'b1, 1'b1, MCX, 1, 'h13, 0, 2, 0, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MCX, 1, 'h21, 1, 0, 0, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MCX, 1, 'h22, 1, 1, 0, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MCX, 1, 'h23, 1, 2, 1, 0, 1, 1));
    tc.push_back(mk(1'b1, 1'b1, MC2, 1, 'h31, 0, 0, 0, 1, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MC2, 1, 'h32, 0, 1, 0, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MC2, 1, 'h33, 0, 2, 0, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MC2, 1, 'h34, 1, 0, 0, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MC2, 1, 'h35, 1, 1, 0, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MC2, 1, 'h36, 1, 2, 1, 0, 1, 1));
    tc.push_back(mk(1'b0, 1'b1, MC2, 0, 0,    0, 0, 0, 1, 0, 1));

    td.push_back(mk(1'b1, 1'b1, MD, 1, 'hA5, 0, 0, 1, 0, 1, 0));
    td.push_back(mk(1'b0, 1'b1, MD, 0, 0,    0, 0, 0, 1, 0, 0));
    td.push_back(mk(1'b0, 1'b1, MD, 0, 0,    0, 0, 0, 0, 0, 0));

    // Reset state: every output low, including data and indices.
    zero_v = mk(1'b0, 1'b0, '0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      vec_t s;
      sample(d, s);
      chk($sformatf("%s.reset.valid", tags[d]), s.valid, 0);
      compare(d, mk(1'b0, 1'b0, '0, 0, 0, 0, 0, 0, 0, 0, 0), {tags[d], ".reset"});
      chk($sformatf("%s.reset.data", tags[d]), s.data, zero_v.data);
      chk($sformatf("%s.reset.idx", tags[d]), s.row + s.col, 0);
      chk($sformatf("%s.reset.last", tags[d]), s.last, 0);
    end
    reset = 1'b0;

    for (int i = 0; i < ta.size(); i++)  run_vec(0, ta[i],  tags[0], i);
    for (int i = 0; i < tbv.size(); i++) run_vec(1, tbv[i], tags[1], i);
    for (int i = 0; i < tc.size(); i++)  run_vec(2, tc[i],  tags[2], i);
    for (int i = 0; i < td.size(); i++)  run_vec(3, td[i],  tags[3], i);

    // Mid-frame reset after one transfer: immediate clear, no frame_done, fresh restart.
    mat_a = 32'h0403_0201;
    if_a.out_ready = 1'b1;
    load_a = 1'b1;
    @(posedge clk);
    #1;
    load_a = 1'b0;
    chk("rst.first", int'(if_a.out_data), 'h01);
    @(posedge clk);
    #1;
    chk("rst.second", int'(if_a.out_data), 'h02);
    chk("rst.ovr_before", int'(ov_c), 1);
    #2;
    reset = 1'b1;
    #1;
    compare(0, mk(1'b0, 1'b0, '0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.async");
    chk("rst.async.data", int'(if_a.out_data), 0);
    chk("rst.async.row", int'(if_a.out_row), 0);
    chk("rst.async.col", int'(if_a.out_col), 0);
    chk("rst.async.last", int'(if_a.out_last), 0);
    chk("rst.async.ovr_c", int'(ov_c), 0);
    @(posedge clk);
    #1;
    chk("rst.held.done", int'(done_a), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.after.done", int'(done_a), 0);
    chk("rst.after.valid", int'(if_a.out_valid), 0);
    load_a = 1'b1;
    @(posedge clk);
    #1;
    load_a = 1'b0;
    compare(0, mk(1'b0, 1'b1, MA, 1, 'h01, 0, 0, 0, 0, 1, 0), "rst.restart0");
    @(posedge clk);
    #1;
    compare(0, mk(1'b0, 1'b1, MA, 1, 'h02, 0, 1, 0, 0, 1, 0), "rst.restart1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_streamer.md
MAT_STREAMER -- requirements
Module: mat_streamer

Interface
REQ-001 SHALL have parameter M, default 0, meaning result matrix rows; elaboration SHALL fail if M is 0.
REQ-002 SHALL have parameter L, default 0, meaning result matrix columns; elaboration SHALL fail if L is 0.
REQ-003 SHALL have parameter WIDTH, default 8, meaning element width in bits.
REQ-004 SHALL have parameter COL_MAJOR, default 0, meaning emission order: 0 is row-major, 1 is column-major.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-007 SHALL have port mat_in, input, M*L*WIDTH bits: flat result matrix; element (r,c) at bits [(r*L+c)*WIDTH +: WIDTH].
REQ-008 SHALL have port load, input, 1 bit: capture request, driven from the multiplier done.
REQ-009 SHALL have port out_data, output, WIDTH bits: current element.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port out_row, output, RW=max(1,clog2(M)) bits: row index of out_data.
REQ-013 SHALL have port out_col, output, CW=max(1,clog2(L)) bits: column index of out_data.
REQ-014 SHALL have port out_last, output, 1 bit: final element of frame.
REQ-015 SHALL have port busy, output, 1 bit: frame held and not yet fully emitted.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the final transfer.
REQ-017 SHALL have port overrun, output, 1 bit: sticky; a load arrived while busy and was dropped.

Function
REQ-018 SHALL implement FSM states IDLE and STREAM.
REQ-019 In IDLE, load=1 SHALL capture mat_in into an internal holding register, zero the indices, and enter STREAM.
REQ-020 out_valid SHALL be 1 starting the cycle after capture; latency from load to first valid SHALL be 1 cycle.
REQ-021 A transfer SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-023 Row-major order SHALL advance the column first, wrapping from L-1 to 0 and incrementing the row; column-major order SHALL advance the row first, symmetrically.
REQ-024 out_last SHALL be 1 exactly when the indices equal (M-1, L-1).
REQ-025 A transfer with out_last=1 SHALL pulse frame_done the next cycle and return the FSM to IDLE, with out_valid=0 and busy=0.
REQ-026 A load coincident with the final transfer SHALL be accepted: the block captures the new frame and stays in STREAM with indices (0,0); out_valid SHALL stay 1, and frame_done SHALL still pulse.
REQ-027 A load in STREAM at any other time SHALL be ignored, SHALL leave held data unchanged, and SHALL set overrun.
REQ-028 out_data SHALL be the held element bits unmodified, with no sign extension or arithmetic.
REQ-029 The design SHALL handle M=1 and/or L=1: a 1x1 frame emits one element with out_last=1.
REQ-030 mat_in SHALL be sampled only at capture; later changes SHALL not affect the frame being emitted.

Reset
REQ-031 reset SHALL asynchronously force IDLE, indices 0, and the holding register 0.
REQ-032 reset SHALL asynchronously force out_valid, out_last, busy, frame_done and overrun to 0, and out_data to 0.
REQ-033 Reset mid-frame SHALL abort the frame with no frame_done; the first post-reset load SHALL start a fresh frame.

Structure
REQ-034 The shared package mmul_pkg SHALL hold the state enum type and a safe-clog2 width function used for RW and CW.
REQ-035 The row/column wrap counter, including order selection and last detection, SHALL be the sub-module mat_idx_counter.

Verification
REQ-036 2x2, WIDTH=8, mat_in elements (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4, out_ready=1 -> data 1,2,3,4 in consecutive cycles from cycle+1; out_last on 4; frame_done one cycle later.
REQ-037 Same stimulus with COL_MAJOR=1 -> data 1,3,2,4; indices (0,0),(1,0),(0,1),(1,1).
REQ-038 out_ready toggling 1,0,0,1 -> each element held stable during stalls; no duplicates or losses.
REQ-039 load during the 2nd element of a 2x3 frame -> overrun=1 and remaining elements from the original frame; a load on the last transfer -> back-to-back frame, out_valid never drops.
REQ-040 reset asserted after 1 transfer -> all outputs 0 asynchronously and no frame_done; next load emits from (0,0).
REQ-041 1x1 frame with value 8'hA5 -> single transfer with out_last=1, then frame_done.
